alu_input_loader: RTL and testbench
===================================

ALU_INPUT_LOADER -- requirements
Module: alu_input_loader

Interface
REQ-001 The block SHALL have parameter BUS_SIZE, default 8, operand width in bits.
REQ-002 The block SHALL have parameter OPCODE_SIZE, default 6, opcode width in bits.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-level cycles required before a button press is accepted.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port sw, input, BUS_SIZE, raw asynchronous switch bank holding the value to load.
REQ-007 The block SHALL have ports btn_num1, btn_num2 and btn_op, input, 1 each, raw asynchronous push buttons, active-high.
REQ-008 The block SHALL have ports num1 and num2, output, BUS_SIZE each, registered operands to the ALU.
REQ-009 The block SHALL have port opcode, output, OPCODE_SIZE, registered opcode to the ALU.
REQ-010 The block SHALL have port ready, output, 1, high while num1, num2 and opcode have all been loaded.
REQ-011 The block SHALL have port op_illegal, output, 1, high while the loaded opcode is not one of ADD, SUB, AND, OR, XOR, NOR, SRL, SRA.
REQ-012 The block SHALL have port state, output, 2, current FSM state encoding for LEDs.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then the conditioner, then a rising-edge detector producing a one-cycle press pulse.
REQ-014 The FSM SHALL have states WAIT_N1 (00), WAIT_N2 (01), WAIT_OP (10), READY (11).
REQ-015 WAIT_N1: num1 press loads num1 from sw and goes to WAIT_N2; num2 and op presses are ignored.
REQ-016 WAIT_N2: num2 press loads num2 from sw and goes to WAIT_OP; num1 press reloads num1 and stays; op press is ignored.
REQ-017 WAIT_OP: op press loads opcode from sw[OPCODE_SIZE-1:0] and goes to READY; num1 and num2 presses reload their operand and stay.
REQ-018 READY: any press reloads the corresponding register in the same cycle and stays in READY; ready stays high.
REQ-019 Registers SHALL update on the clock edge after the press pulse; the press pulse is 2 cycles after the conditioned level rises.
REQ-020 Presses pulsing in the same cycle SHALL be resolved by priority num1 > num2 > op; lower-priority pulses are dropped, not queued.
REQ-021 A held button SHALL generate exactly one press; another press requires release and re-press.
REQ-022 sw bits above OPCODE_SIZE-1 SHALL be ignored on an opcode load.
REQ-023 op_illegal SHALL be combinational on the opcode register and low in reset.
REQ-024 ready SHALL equal (state == READY).

Reset
REQ-025 reset SHALL asynchronously clear num1, num2 and opcode to 0, state to WAIT_N1, and synchronizer, debounce and edge state to 0.
REQ-026 A press in progress during reset SHALL be discarded; a button held through reset release SHALL NOT produce a press until it is released and pressed again.

Configuration
REQ-027 With macro ALU_INPUT_LOADER_DEBOUNCE_EN defined, the conditioner SHALL accept a level change only after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
REQ-028 Without ALU_INPUT_LOADER_DEBOUNCE_EN, the conditioner SHALL pass the synchronized level straight through, and DEBOUNCE_CYCLES SHALL be unused.

Structure
REQ-029 Package alu_pkg SHALL hold BUS_SIZE and OPCODE_SIZE defaults, the eight opcode constants (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011) and the FSM state typedef.
REQ-030 A sub-module btn_conditioner (sync, optional debounce, edge pulse) SHALL be instantiated three times.

Verification
REQ-031 Test 1: reset, then sw=0x0F with num1 press, sw=0x01 with num2 press, sw=0x20 with op press -> num1=0x0F, num2=0x01, opcode=100000, ready=1, op_illegal=0, state=11.
REQ-032 Test 2: from reset, num2 press then op press -> num2=0, opcode=0, state=00.
REQ-033 Test 3: in READY, num1 and op pulses in the same cycle with sw=0xAA -> num1=0xAA, opcode unchanged.
REQ-034 Test 4: op load with sw=0xFF -> opcode=111111, op_illegal=1.
REQ-035 Test 5: with the debounce macro and DEBOUNCE_CYCLES=8, 3-cycle glitches on btn_num1 -> no load; a 10-cycle hold -> exactly one load.
REQ-036 Test 6: reset asserted in WAIT_OP with btn_op held, then released -> all outputs 0, state=00, no load until btn_op is released and pressed again.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU input loader: default operand and opcode
// widths, the eight supported opcode encodings, the loader FSM state type,
// and a helper that classifies a 6-bit opcode as supported or not.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int BUS_SIZE_DEFAULT    = 8;
  localparam int OPCODE_SIZE_DEFAULT = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  // Encodings are shown on the board LEDs, so they are fixed explicitly.
  typedef enum logic [1:0] {
    WAIT_N1 = 2'b00,
    WAIT_N2 = 2'b01,
    WAIT_OP = 2'b10,
    READY   = 2'b11
  } state_t;

  function automatic logic opcode_is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Turns one raw asynchronous push button into a single-cycle press pulse:
// 2-flop synchronizer, optional debounce, then a rising-edge detector.
//
// Configuration macro: ALU_INPUT_LOADER_DEBOUNCE_EN
//   defined   -> a level change is accepted only after DEBOUNCE_CYCLES
//                consecutive stable cycles
//   undefined -> the synchronized level is passed straight through
//
// Ports
//   clk    in  clock
//   reset  in  asynchronous active-high reset
//   btn    in  raw button level (active-high)
//   press  out one-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic [1:0] valid_sr;
  logic       cond;
  logic       cond_d1;
  logic       cond_d2;
  logic       armed;

  // valid_sr marks the point where sync2 holds a real sample of the button
  // rather than its reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      valid_sr <= 2'b00;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      valid_sr <= {valid_sr[0], 1'b1};
    end
  end

`ifdef ALU_INPUT_LOADER_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [CNT_W-1:0] stable_cnt;

  // Count consecutive cycles where the synchronized level disagrees with
  // the accepted level; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond       <= 1'b0;
      stable_cnt <= '0;
    end else if (sync2 != cond) begin
      if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cond       <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_CYCLES > 0);
  assign cond = sync2;
`endif

  // The edge detector only arms after a genuine released level has been
  // seen, so a button held through reset cannot fake a press on release
  // of reset; the press output is one registered pulse per rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_d1 <= 1'b0;
      cond_d2 <= 1'b0;
      armed   <= 1'b0;
      press   <= 1'b0;
    end else begin
      cond_d1 <= cond;
      cond_d2 <= cond_d1;
      armed   <= armed | (valid_sr[1] & ~sync2 & ~cond);
      press   <= armed & cond_d1 & ~cond_d2;
    end
  end

endmodule

// File: rtl/alu_input_loader.sv
// ---------------------------------------------------------------------------
// alu_input_loader
// Loads two operands and an opcode for an ALU from a switch bank, one
// register per push button, sequenced by a small FSM.
//
// Configuration macro: ALU_INPUT_LOADER_DEBOUNCE_EN (button debounce)
//
// Ports
//   clk          in  clock
//   reset        in  asynchronous active-high reset
//   sw           in  switch bank value to load [BUS_SIZE]
//   btn_num1     in  load num1 button
//   btn_num2     in  load num2 button
//   btn_op       in  load opcode button
//   num1, num2   out registered operands [BUS_SIZE]
//   opcode       out registered opcode [OPCODE_SIZE]
//   ready        out all three registers have been loaded
//   op_illegal   out loaded opcode is not a supported operation
//   state        out FSM state for LEDs
// ---------------------------------------------------------------------------
module alu_input_loader
  import alu_pkg::*;
#(
  parameter int BUS_SIZE        = BUS_SIZE_DEFAULT,
  parameter int OPCODE_SIZE     = OPCODE_SIZE_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUS_SIZE-1:0]    sw,
  input  logic                   btn_num1,
  input  logic                   btn_num2,
  input  logic                   btn_op,
  output logic [BUS_SIZE-1:0]    num1,
  output logic [BUS_SIZE-1:0]    num2,
  output logic [OPCODE_SIZE-1:0] opcode,
  output logic                   ready,
  output logic                   op_illegal,
  output logic [1:0]             state
);

  logic   press_n1;
  logic   press_n2;
  logic   press_op;
  logic   op_loaded;
  state_t state_q;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_n1 (
    .clk(clk), .reset(reset), .btn(btn_num1), .press(press_n1)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_n2 (
    .clk(clk), .reset(reset), .btn(btn_num2), .press(press_n2)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_op (
    .clk(clk), .reset(reset), .btn(btn_op), .press(press_op)
  );

  // Simultaneous presses resolve num1 > num2 > op; a losing press is simply
  // dropped. num1 may always be (re)loaded, num2 once num1 exists, and the
  // opcode once both operands exist.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_N1;
      num1      <= '0;
      num2      <= '0;
      opcode    <= '0;
      op_loaded <= 1'b0;
    end else if (press_n1) begin
      num1 <= sw;
      if (state_q == WAIT_N1) state_q <= WAIT_N2;
    end else if (press_n2) begin
      if (state_q != WAIT_N1) begin
        num2 <= sw;
        if (state_q == WAIT_N2) state_q <= WAIT_OP;
      end
    end else if (press_op) begin
      if (state_q == WAIT_OP || state_q == READY) begin
        opcode    <= sw[OPCODE_SIZE-1:0];
        op_loaded <= 1'b1;
        state_q   <= READY;
      end
    end
  end

  // The reset value of opcode (0) is not a supported operation, so the flag
  // is qualified by op_loaded to stay quiet until an opcode was loaded.
  // Upper bits beyond the 6-bit encoding must be zero to be legal.
  logic [31:0] op_ext;
  assign op_ext     = 32'(opcode);
  assign op_illegal = op_loaded & ~((op_ext[31:6] == 26'd0) & opcode_is_legal(op_ext[5:0]));
  assign ready      = (state_q == READY);
  assign state      = state_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// ---------------------------------------------------------------------------
// tb_alu_input_loader
// Scoreboard bench: each button action updates a reference model and
// queues the expected output snapshot with a due cycle; a monitor pops and
// compares snapshots as they fall due.
// ---------------------------------------------------------------------------
module tb_alu_input_loader;

`ifdef ALU_INPUT_LOADER_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif
  localparam int HOLD = 6 + DB;
  localparam int GAP  = 6 + DB;
  localparam int LAT  = 8 + DB;

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic       btn_num1;
  logic       btn_num2;
  logic       btn_op;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [5:0] opcode;
  logic       ready;
  logic       op_illegal;
  logic [1:0] state;

  alu_input_loader #(
    .BUS_SIZE(8), .OPCODE_SIZE(6), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .btn_num1(btn_num1), .btn_num2(btn_num2), .btn_op(btn_op),
    .num1(num1), .num2(num2), .opcode(opcode),
    .ready(ready), .op_illegal(op_illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    logic [7:0] n1;
    logic [7:0] n2;
    logic [5:0] op;
    logic [1:0] st;
    logic       rdy;
    logic       ill;
    int         due;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: loading progress counted 0..3, plus the three registers.
  logic [7:0] m_n1, m_n2;
  logic [5:0] m_op;
  int         m_stage;
  bit         m_loaded;

  function automatic bit legal(input logic [5:0] op);
    logic [5:0] tbl [8];
    tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
    foreach (tbl[i]) if (tbl[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    m_n1 = 8'h00; m_n2 = 8'h00; m_op = 6'h00; m_stage = 0; m_loaded = 1'b0;
  endtask

  // Only the highest-priority button counts; its load needs all earlier
  // registers to be present already.
  task automatic modelPress(input bit p1, input bit p2, input bit po, input logic [7:0] s);
    if (p1) begin
      m_n1 = s;
      if (m_stage == 0) m_stage = 1;
    end else if (p2) begin
      if (m_stage >= 1) begin
        m_n2 = s;
        if (m_stage == 1) m_stage = 2;
      end
    end else if (po) begin
      if (m_stage >= 2) begin
        m_op     = s[5:0];
        m_loaded = 1'b1;
        m_stage  = 3;
      end
    end
  endtask

  task automatic pushExpect(input string tag, input int delay);
    exp_t e;
    e.n1  = m_n1;
    e.n2  = m_n2;
    e.op  = m_op;
    e.st  = 2'(m_stage);
    e.rdy = (m_stage == 3);
    e.ill = m_loaded && !legal(m_op);
    e.due = cycle + delay;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each queued snapshot once it falls due.
  always @(negedge clk) begin
    if (!reset && sb.size() > 0 && sb[0].due <= cycle) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput({e.tag, ".num1"},       32'(num1),       32'(e.n1));
      checkOutput({e.tag, ".num2"},       32'(num2),       32'(e.n2));
      checkOutput({e.tag, ".opcode"},     32'(opcode),     32'(e.op));
      checkOutput({e.tag, ".state"},      32'(state),      32'(e.st));
      checkOutput({e.tag, ".ready"},      32'(ready),      32'(e.rdy));
      checkOutput({e.tag, ".op_illegal"}, 32'(op_illegal), 32'(e.ill));
    end
  end

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d pending snapshots expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input string tag, input bit p1, input bit p2, input bit po,
                               input logic [7:0] s, input int hold, input logic [7:0] s_after);
    @(negedge clk);
    sw = s;
    btn_num1 = p1;
    btn_num2 = p2;
    btn_op   = po;
    modelPress(p1, p2, po, s);
    pushExpect(tag, LAT);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == LAT) sw = s_after;
    end
    btn_num1 = 1'b0;
    btn_num2 = 1'b0;
    btn_op   = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    drain();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelReset();
    pushExpect(tag, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; sw = 8'h00;
    btn_num1 = 1'b0; btn_num2 = 1'b0; btn_op = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pushExpect("reset_state", 1);
    repeat (5) @(negedge clk);

    // Full load sequence ending in READY with ADD.
    applyStimulus("t1_n1", 1, 0, 0, 8'h0F, HOLD, 8'h0F);
    applyStimulus("t1_n2", 0, 1, 0, 8'h01, HOLD, 8'h01);
    applyStimulus("t1_op", 0, 0, 1, 8'h20, HOLD, 8'h20);

    // Simultaneous num1 + op in READY: only num1 loads.
    applyStimulus("t3_same", 1, 0, 1, 8'hAA, HOLD, 8'hAA);

    // Upper switch bits dropped, unsupported opcode flagged.
    applyStimulus("t4_op_ff", 0, 0, 1, 8'hFF, HOLD, 8'hFF);

    // Held button loads once; later switch changes are not picked up.
    applyStimulus("held", 0, 1, 0, 8'h3C, LAT + 12, 8'hC3);
    pushExpect("held_once", 1);
    repeat (3) @(negedge clk);

    // Out-of-order presses from reset are ignored.
    doReset("t2_reset");
    applyStimulus("t2_n2", 0, 1, 0, 8'h77, HOLD, 8'h77);
    applyStimulus("t2_op", 0, 0, 1, 8'h20, HOLD, 8'h20);

`ifdef ALU_INPUT_LOADER_DEBOUNCE_EN
    // Short glitches are rejected; a 10-cycle hold loads exactly once.
    drain();
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      sw = 8'h99;
      btn_num1 = 1'b1;
      repeat (3) @(negedge clk);
      btn_num1 = 1'b0;
      repeat (12) @(negedge clk);
    end
    pushExpect("t5_glitch", 1);
    repeat (3) @(negedge clk);
    applyStimulus("t5_hold", 1, 0, 0, 8'h99, 10, 8'h99);
    pushExpect("t5_once", 1);
    repeat (3) @(negedge clk);
`endif

    // Buttons held through reset must not load until re-pressed.
    doReset("t6_pre");
    applyStimulus("t6_n1", 1, 0, 0, 8'h11, HOLD, 8'h11);
    applyStimulus("t6_n2", 0, 1, 0, 8'h22, HOLD, 8'h22);
    drain();
    @(negedge clk);
    sw = 8'h5A;
    btn_op = 1'b1;
    btn_num1 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelReset();
    pushExpect("t6_held", 30);
    repeat (40) @(negedge clk);
    btn_op = 1'b0;
    btn_num1 = 1'b0;
    repeat (GAP + 4) @(negedge clk);
    pushExpect("t6_released", 1);
    repeat (3) @(negedge clk);
    applyStimulus("t6_repress", 1, 0, 0, 8'h5A, HOLD, 8'h5A);

    // Random button combinations and switch values.
    doReset("rand_reset");
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  combo;
      logic [7:0]  val;
      combo = 3'($urandom_range(1, 7));
      val   = 8'($urandom);
      applyStimulus("rand", combo[0], combo[1], combo[2], val, HOLD, val);
    end

    drain();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
